// File: rtl/lut_ram_pkg.sv
// Shared types and helpers for the multi-read-port LUT RAM.
//   BYTE_W          : width of one byte lane of the write port
//   lut_clr_state_e : clear sequencer states
//   lut_addr_w()    : address width for a given depth
package lut_ram_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {ST_IDLE, ST_CLEAR} lut_clr_state_e;

  function automatic int unsigned lut_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/lut_ram_mp_if.sv
// Bus bundle of the multi-read-port LUT RAM.
//   master : user side (drives clr_req, write port, read strobes/addresses)
//   slave  : RAM side (drives busy, wr_drop, rd_data, rd_valid)
interface lut_ram_mp_if
  import lut_ram_pkg::*;
#(
  parameter int unsigned LUT_WIDTH    = 32,
  parameter int unsigned LUT_DEPTH    = 256,
  parameter int unsigned NUM_RD_PORTS = 2
);

  localparam int unsigned AW = lut_addr_w(LUT_DEPTH);
  localparam int unsigned NB = LUT_WIDTH / BYTE_W;

  logic                    clr_req;
  logic                    busy;
  logic                    wr_en;
  logic [NB-1:0]           wr_be;
  logic [AW-1:0]           wr_addr;
  logic [LUT_WIDTH-1:0]    wr_data;
  logic                    wr_drop;
  logic [NUM_RD_PORTS-1:0] rd_en;
  logic [AW-1:0]           rd_addr [NUM_RD_PORTS];
  logic [LUT_WIDTH-1:0]    rd_data [NUM_RD_PORTS];
  logic [NUM_RD_PORTS-1:0] rd_valid;

  modport master (
    output clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    input  busy, wr_drop, rd_data, rd_valid
  );

  modport slave (
    input  clr_req, wr_en, wr_be, wr_addr, wr_data, rd_en, rd_addr,
    output busy, wr_drop, rd_data, rd_valid
  );

endinterface

// File: rtl/lut_ram_clear_fsm.sv
// Clear sequencer: sweeps every entry once, writing zero, after reset
// (when CLEAR_ON_RESET is set) or on clr_req while idle.
//   clk, rst : clock, asynchronous active-high reset
//   clr_req  : start a sweep (honoured in IDLE only)
//   busy     : sweep in progress
//   clr_we   : zero-write strobe to the array
//   clr_addr : entry being zeroed
module lut_ram_clear_fsm
  import lut_ram_pkg::*;
#(
  parameter int unsigned LUT_DEPTH      = 256,
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned AW             = lut_addr_w(LUT_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam lut_clr_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(LUT_DEPTH - 1);

  lut_clr_state_e state_q, state_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           busy_q;

  // State, pointer and busy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      ptr_q   <= '0;
      busy_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= (state_d == ST_CLEAR);
    end
  end

  // Next-state: one entry per cycle, back to IDLE after the last one
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // busy_q tracks state_q == ST_CLEAR exactly, so it doubles as the write strobe
  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/lut_ram_mp.sv
// Multi-read-port LUT RAM: one byte-enabled write port, NUM_RD_PORTS
// registered read ports, built-in clear sequencer.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lut_ram_mp_if.slave (clr_req/busy, write port + wr_drop,
//              per-port rd_en/rd_addr/rd_data/rd_valid)
// Optional feature macro: LUT_RAM_MP_BYPASS_EN
//   defined   : a read colliding with an accepted write returns the merged new word
//   undefined : a colliding read returns the pre-write contents
module lut_ram_mp
  import lut_ram_pkg::*;
#(
  parameter int unsigned LUT_WIDTH      = 32,
  parameter int unsigned LUT_DEPTH      = 256,
  parameter int unsigned NUM_RD_PORTS   = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic         clk,
  input logic         rst,
  lut_ram_mp_if.slave bus
);

  localparam int unsigned AW = lut_addr_w(LUT_DEPTH);
  localparam int unsigned NB = LUT_WIDTH / BYTE_W;
  localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(LUT_DEPTH);

  logic                 clr_we;
  logic [AW-1:0]        clr_addr;
  logic                 wr_in_range;
  logic                 wr_accept;
  logic                 wr_drop_q;
  logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];

  lut_ram_clear_fsm #(
    .LUT_DEPTH      (LUT_DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .AW             (AW)
  ) u_clear_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (bus.busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // A user write lands only when idle, no clear is starting, and the address exists
  assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign wr_accept   = bus.wr_en & ~clr_we & ~bus.clr_req & wr_in_range;

  // Writes lost to a running or starting sweep are reported; out-of-range ones are not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_drop_q <= 1'b0;
    else     wr_drop_q <= bus.wr_en & (clr_we | bus.clr_req);
  end
  assign bus.wr_drop = wr_drop_q;

  // Array write: clear sweep has priority over the user port
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_accept) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_be[b]) mem[bus.wr_addr][b*BYTE_W +: BYTE_W] <= bus.wr_data[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read ports
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic                 in_range;
    logic [LUT_WIDTH-1:0] old_word;
    logic [LUT_WIDTH-1:0] rd_word;
    logic [LUT_WIDTH-1:0] data_q;
    logic                 valid_q;

    assign in_range = ({1'b0, bus.rd_addr[p]} < DEPTH_EXT);
    assign old_word = in_range ? mem[bus.rd_addr[p]] : '0;

`ifdef LUT_RAM_MP_BYPASS_EN
    // Forward enabled bytes of a same-cycle accepted write
    always_comb begin
      rd_word = old_word;
      if (wr_accept && (bus.wr_addr == bus.rd_addr[p])) begin
        for (int b = 0; b < NB; b++) begin
          if (bus.wr_be[b]) rd_word[b*BYTE_W +: BYTE_W] = bus.wr_data[b*BYTE_W +: BYTE_W];
        end
      end
    end
`else
    assign rd_word = old_word;
`endif

    // Data holds when not strobed; a sweep forces zero
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= bus.rd_en[p];
        if (bus.rd_en[p]) data_q <= clr_we ? '0 : rd_word;
      end
    end

    assign bus.rd_data[p]  = data_q;
    assign bus.rd_valid[p] = valid_q;
  end

endmodule

// File: tb/tb_lut_ram_mp.sv
// Self-checking bench for lut_ram_mp: directed steps on a 256-deep instance,
// out-of-range and randomized checks on a 200-deep, 3-port instance.
module tb_lut_ram_mp;

  localparam int unsigned W  = 32;
  localparam int unsigned DA = 256;
  localparam int unsigned DB = 200;
  localparam int unsigned PA = 2;
  localparam int unsigned PB = 3;

`ifdef LUT_RAM_MP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_ram_mp_if #(.LUT_WIDTH(W), .LUT_DEPTH(DA), .NUM_RD_PORTS(PA)) ia ();
  lut_ram_mp_if #(.LUT_WIDTH(W), .LUT_DEPTH(DB), .NUM_RD_PORTS(PB)) ib ();

  lut_ram_mp #(.LUT_WIDTH(W), .LUT_DEPTH(DA), .NUM_RD_PORTS(PA), .CLEAR_ON_RESET(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ia)
  );
  lut_ram_mp #(.LUT_WIDTH(W), .LUT_DEPTH(DB), .NUM_RD_PORTS(PB), .CLEAR_ON_RESET(1)) dut_b (
    .clk (clk), .rst (rst), .bus (ib)
  );

  int tests = 0;
  int fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model of dut_b: plain array plus per-port expected outputs
  logic [W-1:0] mb      [DB];
  logic [W-1:0] eb_data [PB];
  logic [PB-1:0] eb_valid;

  logic         we;
  logic [7:0]   wa;
  logic [3:0]   be;
  logic [W-1:0] wd;
  logic [7:0]   ra;
  logic [W-1:0] v;
  int           n;

  initial begin
    ia.clr_req = 1'b0; ia.wr_en = 1'b0; ia.wr_be = '0; ia.wr_addr = '0; ia.wr_data = '0;
    ia.rd_en = '0;
    for (int p = 0; p < PA; p++) ia.rd_addr[p] = '0;
    ib.clr_req = 1'b0; ib.wr_en = 1'b0; ib.wr_be = '0; ib.wr_addr = '0; ib.wr_data = '0;
    ib.rd_en = '0;
    for (int p = 0; p < PB; p++) ib.rd_addr[p] = '0;
    for (int i = 0; i < DB; i++) mb[i] = '0;
    for (int p = 0; p < PB; p++) eb_data[p] = '0;
    eb_valid = '0;

    // Reset state (read strobes held high to show they are ignored)
    ia.rd_en = 2'b11;
    repeat (3) step();
    chk("rst_busy", W'(ia.busy), 32'd1);
    chk("rst_wr_drop", W'(ia.wr_drop), 32'd0);
    chk("rst_rd_valid", W'(ia.rd_valid), 32'd0);
    chk("rst_rd_data0", ia.rd_data[0], 32'd0);
    ia.rd_en = '0;

    // 1: reset sweep lasts exactly DEPTH cycles
    rst = 1'b0;
    chk("sweep_busy_start", W'(ia.busy), 32'd1);
    n = 0;
    while (ia.busy && n < 400) begin step(); n++; end
    chk("sweep_len_reset", W'(n), W'(DA));
    ia.rd_en = 2'b11; ia.rd_addr[0] = 8'd0; ia.rd_addr[1] = 8'd255;
    step();
    chk("clr_rd_addr0", ia.rd_data[0], 32'd0);
    chk("clr_rd_addr255", ia.rd_data[1], 32'd0);
    chk("clr_rd_valid", W'(ia.rd_valid), 32'd3);
    ia.rd_en = '0;

    // 2: byte-enabled partial write
    ia.wr_en = 1'b1; ia.wr_addr = 8'd5; ia.wr_be = 4'b1111; ia.wr_data = 32'hDEADBEEF;
    step();
    chk("wr_no_drop", W'(ia.wr_drop), 32'd0);
    ia.wr_be = 4'b0010; ia.wr_data = 32'h0000AA00;
    step();
    ia.wr_en = 1'b0;
    ia.rd_en = 2'b01; ia.rd_addr[0] = 8'd5;
    step();
    chk("be_merge", ia.rd_data[0], 32'hDEADAAEF);
    chk("be_merge_valid", W'(ia.rd_valid), 32'd1);
    ia.rd_en = '0;
    step();
    chk("hold_valid", W'(ia.rd_valid), 32'd0);
    chk("hold_data", ia.rd_data[0], 32'hDEADAAEF);

    // 3: same-cycle write and read; both ports on the same address
    ia.wr_en = 1'b1; ia.wr_addr = 8'd7; ia.wr_be = 4'b1111; ia.wr_data = 32'h12345678;
    ia.rd_en = 2'b11; ia.rd_addr[0] = 8'd7; ia.rd_addr[1] = 8'd7;
    step();
    chk("collide_p0", ia.rd_data[0], BYPASS ? 32'h12345678 : 32'h0);
    chk("collide_p1", ia.rd_data[1], BYPASS ? 32'h12345678 : 32'h0);
    ia.wr_be = 4'b0000; ia.wr_data = 32'hFFFFFFFF;
    step();
    chk("after_write_p0", ia.rd_data[0], 32'h12345678);
    chk("after_write_p1", ia.rd_data[1], 32'h12345678);
    ia.wr_en = 1'b0;
    step();
    chk("be_zero_noop", ia.rd_data[0], 32'h12345678);
    ia.rd_en = '0;

    // 4: clear with coincident write, then a write two cycles into the sweep
    ia.wr_en = 1'b1; ia.wr_addr = 8'd3; ia.wr_be = 4'b1111; ia.wr_data = 32'hCAFEF00D;
    step();
    ia.clr_req = 1'b1; ia.wr_data = 32'h11111111;
    step();
    chk("clr_vs_wr_drop", W'(ia.wr_drop), 32'd1);
    chk("clr_busy", W'(ia.busy), 32'd1);
    ia.clr_req = 1'b0; ia.wr_en = 1'b0;
    n = 0;
    step(); n++;
    chk("drop_one_pulse", W'(ia.wr_drop), 32'd0);
    ia.wr_en = 1'b1; ia.wr_data = 32'h55555555;
    ia.rd_en = 2'b01; ia.rd_addr[0] = 8'd5;
    step(); n++;
    chk("busy_wr_drop", W'(ia.wr_drop), 32'd1);
    chk("busy_rd_zero", ia.rd_data[0], 32'd0);
    chk("busy_rd_valid", W'(ia.rd_valid), 32'd1);
    ia.wr_en = 1'b0; ia.rd_en = '0;
    while (ia.busy && n < 400) begin step(); n++; end
    chk("sweep_len_req", W'(n), W'(DA));
    ia.rd_en = 2'b11; ia.rd_addr[0] = 8'd3; ia.rd_addr[1] = 8'd5;
    step();
    chk("cleared_addr3", ia.rd_data[0], 32'd0);
    chk("cleared_addr5", ia.rd_data[1], 32'd0);
    ia.rd_en = '0;

    // 5: reset in the middle of a sweep
    ia.wr_en = 1'b1; ia.wr_addr = 8'd20; ia.wr_be = 4'b1111; ia.wr_data = 32'hA5A5A5A5;
    step();
    ia.wr_en = 1'b0; ia.rd_en = 2'b01; ia.rd_addr[0] = 8'd20;
    step();
    chk("pre_rst_read", ia.rd_data[0], 32'hA5A5A5A5);
    ia.rd_en = 2'b10; ia.rd_addr[1] = 8'd20; ia.clr_req = 1'b1;
    step();
    ia.clr_req = 1'b0;
    repeat (100) step();
    chk("mid_sweep_hold", ia.rd_data[0], 32'hA5A5A5A5);
    chk("mid_sweep_valid", W'(ia.rd_valid), 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_data", ia.rd_data[0], 32'd0);
    chk("async_rst_valid", W'(ia.rd_valid), 32'd0);
    chk("async_rst_busy", W'(ia.busy), 32'd1);
    ia.rd_en = '0;
    step(); step();
    rst = 1'b0;
    n = 0;
    while (ia.busy && n < 400) begin step(); n++; end
    chk("sweep_len_rerst", W'(n), W'(DA));

    // 6: dut_b (depth 200): in-range, boundary and out-of-range accesses
    ib.wr_en = 1'b1; ib.wr_be = 4'b1111;
    ib.wr_addr = 8'd9;   ib.wr_data = 32'h13579BDF; step();
    ib.wr_addr = 8'd199; ib.wr_data = 32'h0F0F0F0F; step();
    ib.wr_addr = 8'd210; ib.wr_data = 32'hDEADBEEF; step();
    chk("oor_wr_no_drop", W'(ib.wr_drop), 32'd0);
    ib.wr_en = 1'b0;
    mb[9] = 32'h13579BDF; mb[199] = 32'h0F0F0F0F;
    ib.rd_en = 3'b111; ib.rd_addr[0] = 8'd9; ib.rd_addr[1] = 8'd230; ib.rd_addr[2] = 8'd199;
    step();
    chk("b_addr9", ib.rd_data[0], 32'h13579BDF);
    chk("b_oor230", ib.rd_data[1], 32'd0);
    chk("b_last199", ib.rd_data[2], 32'h0F0F0F0F);
    chk("b_valid", W'(ib.rd_valid), 32'd7);
    eb_data[0] = 32'h13579BDF; eb_data[1] = 32'd0; eb_data[2] = 32'h0F0F0F0F;

    // Randomized traffic on dut_b against the array model
    for (int cyc = 0; cyc < 400; cyc++) begin
      we = 1'($urandom_range(0, 1));
      wa = 8'($urandom_range(0, 255));
      be = 4'($urandom);
      wd = $urandom;
      ib.wr_en = we; ib.wr_addr = wa; ib.wr_be = be; ib.wr_data = wd;
      for (int p = 0; p < PB; p++) begin
        eb_valid[p] = ($urandom_range(0, 2) != 0);
        ra = ($urandom_range(0, 3) == 0) ? wa : 8'($urandom_range(0, 255));
        ib.rd_en[p] = eb_valid[p];
        ib.rd_addr[p] = ra;
        if (eb_valid[p]) begin
          v = (int'(ra) < DB) ? mb[int'(ra)] : 32'd0;
          if (BYPASS && we && int'(wa) < DB && ra == wa) begin
            for (int b = 0; b < 4; b++) if (be[b]) v[b*8 +: 8] = wd[b*8 +: 8];
          end
          eb_data[p] = v;
        end
      end
      if (we && int'(wa) < DB) begin
        for (int b = 0; b < 4; b++) if (be[b]) mb[int'(wa)][b*8 +: 8] = wd[b*8 +: 8];
      end
      step();
      chk("rand_valid", W'(ib.rd_valid), W'(eb_valid));
      for (int p = 0; p < PB; p++) chk($sformatf("rand_data_p%0d_c%0d", p, cyc), ib.rd_data[p], eb_data[p]);
      chk("rand_wr_drop", W'(ib.wr_drop), 32'd0);
    end
    ib.wr_en = 1'b0; ib.rd_en = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
